// File: rtl/remote_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : remote_controller_pkg
// Description : Shared types and constants for the IR remote decoder: FSM
//               state type, frame length, checksum constant and key table.
// Revision    : 1.0 - initial release
// ============================================================================
package remote_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    CHECK     = 2'd2,
    WAIT_HIGH = 2'd3
  } rc_state_t;

  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = 6;

  // A byte plus its bitwise complement always sums to all-ones.
  localparam logic [7:0] SUM_OK = 8'hFF;

  localparam int KEY_COUNT = 16;
  localparam logic [7:0] KEY_TABLE [KEY_COUNT] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
    8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h1A, 8'h1E, 8'h1F
  };

endpackage
`default_nettype wire

// File: rtl/remote_key_lut.sv
`default_nettype none
// ============================================================================
// Module      : remote_key_lut
// Description : Combinational key-table lookup; hit=1 when code is a known key.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_key_lut
  import remote_controller_pkg::*;
(
  input  logic [7:0] code,
  output logic       hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (code == KEY_TABLE[i]) begin
        hit = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/remote_controller.sv
`default_nettype none
// ============================================================================
// Module      : remote_controller
// Description : Serial IR frame decoder (start bit + addr/~addr/cmd/~cmd, LSB
//               first). Define REMOTE_ADDR_CHECK_EN to also validate address.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_controller
  import remote_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       serial,
  output logic [7:0] tecla,
  output logic       ready
);

  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(FRAME_BITS - 1);

  rc_state_t             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_BITS-1:0] r_shift;

  logic [7:0] w_addr;
  logic [7:0] w_addr_n;
  logic [7:0] w_cmd;
  logic [7:0] w_cmd_n;
  logic [7:0] w_cmd_sum;
  logic       w_cmd_ok;
  logic       w_addr_ok;
  logic       w_key_hit;
  logic       w_valid;

  // Bits enter at the MSB and shift down, so the first bit lands in bit 0.
  assign w_addr    = r_shift[7:0];
  assign w_addr_n  = r_shift[15:8];
  assign w_cmd     = r_shift[23:16];
  assign w_cmd_n   = r_shift[31:24];
  assign w_cmd_sum = w_cmd + w_cmd_n;
  assign w_cmd_ok  = (w_cmd_sum == SUM_OK);

`ifdef REMOTE_ADDR_CHECK_EN
  logic [7:0] w_addr_sum;
  assign w_addr_sum = w_addr + w_addr_n;
  assign w_addr_ok  = (w_addr_sum == SUM_OK);
`else
  logic w_addr_unused;
  assign w_addr_unused = ^{w_addr, w_addr_n};
  assign w_addr_ok     = 1'b1;
`endif

  assign w_valid = w_cmd_ok && w_addr_ok && w_key_hit;

  remote_key_lut u_key_lut (
    .code (w_cmd),
    .hit  (w_key_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      tecla   <= 8'h00;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!serial) begin
            r_state <= RECV;
            r_cnt   <= '0;
          end
        end
        RECV: begin
          r_shift <= {serial, r_shift[FRAME_BITS-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last_bit) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_valid) begin
            tecla <= w_cmd;
            ready <= 1'b1;
          end
          r_state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          // A held-low line must idle high before another start bit counts.
          if (serial) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_remote_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_remote_controller
// Description : Directed self-checking bench for remote_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_controller;

  logic       clk;
  logic       rst;
  logic       serial;
  logic [7:0] tecla;
  logic       ready;

  int n_cmp;
  int n_err;
  int pulses;

  logic       r33;
  logic       r34;
  logic [7:0] t33;

  remote_controller dut (
    .clk    (clk),
    .rst    (rst),
    .serial (serial),
    .tecla  (tecla),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ready) pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    serial = 1'b1;
    repeat (n) tick();
  endtask

  // Sends start bit + 32 data bits, then drives 'tail' through E33 and E34,
  // capturing ready/tecla just after each of those two edges.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] na,
                            input logic [7:0] c, input logic [7:0] nc,
                            input logic tail, input int idle_after);
    logic [31:0] f;
    f = {nc, c, na, a};
    pulses = 0;
    serial = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) begin
      serial = f[i];
      tick();
    end
    serial = tail;
    tick();
    r33 = ready;
    t33 = tecla;
    tick();
    r34 = ready;
    if (idle_after > 0) idle(idle_after);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    pulses = 0;
    rst    = 1'b1;
    serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tecla", {24'h0, tecla}, 32'h00);
    check("rst_ready", {31'h0, ready}, 32'h0);
    rst = 1'b0;
    idle(4);
    check("idle_ready", {31'h0, ready}, 32'h0);

    send_frame(8'h00, 8'hFF, 8'h09, 8'hF6, 1'b1, 4);
    check("f09_ready_e33", {31'h0, r33}, 32'h1);
    check("f09_tecla_e33", {24'h0, t33}, 32'h09);
    check("f09_ready_e34", {31'h0, r34}, 32'h0);
    check("f09_pulses", pulses, 1);

    send_frame(8'h00, 8'hFF, 8'h09, 8'hF5, 1'b1, 4);
    check("badsum_ready", {31'h0, r33}, 32'h0);
    check("badsum_tecla", {24'h0, tecla}, 32'h09);
    check("badsum_pulses", pulses, 0);

    send_frame(8'h00, 8'hFF, 8'h55, 8'hAA, 1'b1, 4);
    check("notkey_ready", {31'h0, r33}, 32'h0);
    check("notkey_tecla", {24'h0, tecla}, 32'h09);

    send_frame(8'h00, 8'hFF, 8'h0A, 8'hF5, 1'b1, 4);
    check("key0a_ready", {31'h0, r33}, 32'h0);
    check("key0a_tecla", {24'h0, tecla}, 32'h09);

    send_frame(8'hA5, 8'h5A, 8'h12, 8'hED, 1'b1, 4);
    check("key12_ready", {31'h0, r33}, 32'h1);
    check("key12_tecla", {24'h0, t33}, 32'h12);

    send_frame(8'h00, 8'hFF, 8'h10, 8'hEF, 1'b1, 4);
    check("key10_tecla", {24'h0, t33}, 32'h10);

    send_frame(8'h00, 8'hFF, 8'h1F, 8'hE0, 1'b1, 4);
    check("key1f_tecla", {24'h0, t33}, 32'h1F);
    check("key1f_ready", {31'h0, r33}, 32'h1);
    check("key1f_pulses", pulses, 1);

    send_frame(8'h00, 8'h00, 8'h09, 8'hF6, 1'b1, 4);
`ifdef REMOTE_ADDR_CHECK_EN
    check("addrbad_ready", {31'h0, r33}, 32'h0);
    check("addrbad_tecla", {24'h0, tecla}, 32'h1F);
`else
    check("addrbad_ready", {31'h0, r33}, 32'h1);
    check("addrbad_tecla", {24'h0, tecla}, 32'h09);
`endif

    // Line held low after the frame: decoder must wait for high first.
    send_frame(8'h00, 8'hFF, 8'h1A, 8'hE5, 1'b0, 0);
    check("key1a_tecla", {24'h0, t33}, 32'h1A);
    serial = 1'b0;
    repeat (3) tick();
    check("holdlow_ready", {31'h0, ready}, 32'h0);
    idle(2);
    send_frame(8'h00, 8'hFF, 8'h11, 8'hEE, 1'b1, 4);
    check("afterlow_tecla", {24'h0, t33}, 32'h11);
    check("afterlow_pulses", pulses, 1);

    // Reset asserted part way through a valid frame.
    begin
      logic [31:0] f;
      f = {8'hE1, 8'h1E, 8'hFF, 8'h00};
      pulses = 0;
      serial = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
        serial = f[i];
        tick();
      end
      #2;
      rst = 1'b1;
      #1;
      check("midrst_tecla", {24'h0, tecla}, 32'h00);
      check("midrst_ready", {31'h0, ready}, 32'h0);
      serial = 1'b1;
      tick();
      rst = 1'b0;
      idle(40);
      check("midrst_pulses", pulses, 0);
      check("midrst_hold", {24'h0, tecla}, 32'h00);
    end
    send_frame(8'h00, 8'hFF, 8'h03, 8'hFC, 1'b1, 4);
    check("postrst_tecla", {24'h0, t33}, 32'h03);
    check("postrst_ready", {31'h0, r33}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/remote_controller.md
REMOTE_CONTROLLER -- requirements
Module: remote_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 serial  input  1  IR line; idle high, one bit per clk cycle, sampled on rising edge.
REQ-005 tecla  output  8  last accepted key code, registered.
REQ-006 ready  output  1  one-cycle pulse, tecla updated this cycle.

Function
REQ-007 Frame format SHALL be: start bit (0), then 32 data bits, byte order address, ~address, command, ~command, each byte LSB first; the line then returns high.
REQ-008 FSM states SHALL be IDLE, RECV, CHECK, WAIT_HIGH.
REQ-009 IDLE: serial=0 sampled on edge E0 SHALL move to RECV with bit counter cleared; serial=1 stays IDLE.
REQ-010 RECV: edges E1..E32 SHALL shift one bit each into a 32-bit register; after E32, move to CHECK.
REQ-011 CHECK (edge E33): frame valid iff command+~command == 8'hFF (8-bit modulo sum) and the command is in the key table; if valid, tecla <= command and ready <= 1; state -> WAIT_HIGH.
REQ-012 Invalid frame SHALL leave tecla unchanged and ready at 0; no error output.
REQ-013 ready SHALL be high for exactly one cycle (E33 to E34) per valid frame.
REQ-014 WAIT_HIGH SHALL return to IDLE on the first edge sampling serial=1; serial=0 remains in WAIT_HIGH (no new frame until the line idles).
REQ-015 Key table SHALL contain exactly: 0x00-0x09, 0x10, 0x11, 0x12, 0x1A, 0x1E, 0x1F; all other commands are out-of-table.
REQ-016 Frame-to-frame: a new start bit is accepted on any edge after WAIT_HIGH->IDLE; back-to-back frames separated by >=1 idle-high cycle SHALL decode correctly.
REQ-017 Bit counter SHALL be 6 bits wide; no wrap-around within a frame.

Reset
REQ-018 rst=1 SHALL immediately force state IDLE, counter 0, shift register 0, tecla 8'h00, ready 0.
REQ-019 Reset during RECV/CHECK SHALL discard the partial frame; no ready pulse.

Configuration
REQ-020 Macro REMOTE_ADDR_CHECK_EN defined: validity SHALL additionally require address+~address == 8'hFF.
REQ-021 Macro undefined: address bytes SHALL be received but ignored.

Structure
REQ-022 Package remote_controller_pkg SHALL hold the FSM state type, FRAME_BITS=32, the key-table constants, and the address check constant 8'hFF.
REQ-023 Key-table membership SHALL be a combinational sub-module remote_key_lut (input 8-bit code, output 1-bit hit).

Verification
REQ-024 Frame addr 0x00/0xFF, cmd 0x09/0xF6 -> after E33 tecla=0x09, ready=1 for one cycle.
REQ-025 Frame cmd 0x09/0xF5 (sum 0xFE) -> ready stays 0, tecla holds previous value.
REQ-026 Frame cmd 0x55/0xAA (complement OK, not in table) -> ready stays 0, tecla unchanged.
REQ-027 Frame cmd 0x1F/0xE0 following prior frames with 4 idle-high cycles -> tecla=0x1F, single ready pulse.
REQ-028 rst asserted at bit 15 of a valid frame -> tecla=0x00, ready=0, next full frame decodes normally.
REQ-029 With REMOTE_ADDR_CHECK_EN: addr 0x00/0x00, cmd 0x09/0xF6 -> no ready; without macro -> tecla=0x09, ready pulse.
